// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its address decoder.
// Slave indices follow the 4 KB page order inside the APB region.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  localparam int unsigned APB_NUM_SLV = 4;

  localparam int unsigned SLV_GPIO  = 0;
  localparam int unsigned SLV_UART  = 1;
  localparam int unsigned SLV_TIMER = 2;
  localparam int unsigned SLV_RSVD  = 3;

endpackage

// File: rtl/apb_decoder.sv
// Combinational page decoder: maps address bits [31:12] onto a one-hot slave select.
// Used both for request decode and for steering PREADY/PRDATA back from the bus.
module apb_decoder
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic [19:0]            addr_page,
  output logic [APB_NUM_SLV-1:0] sel,
  output logic                   hit
);

  // addr_page[19:4] is the region tag, addr_page[3:0] the 4 KB page number
  always_comb begin
    hit = (addr_page[19:4] == BASE_ADDR[31:16]) &&
          (addr_page[3:0] <= 4'(SLV_RSVD));
    sel = '0;
    for (int i = 0; i < APB_NUM_SLV; i++) begin
      sel[i] = hit && (addr_page[1:0] == 2'(i));
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: takes one core load/store, runs SETUP/ACCESS on the decoded slave
// and returns read data with a one-cycle ready pulse (err on decode miss or timeout).
module apb_master
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic                   PENABLE,
  output logic [31:0]            PWDATA,
  output logic [APB_NUM_SLV-1:0] PSEL,
  input  logic [31:0]            PRDATA0,
  input  logic [31:0]            PRDATA1,
  input  logic [31:0]            PRDATA2,
  input  logic [31:0]            PRDATA3,
  input  logic                   PREADY0,
  input  logic                   PREADY1,
  input  logic                   PREADY2,
  input  logic                   PREADY3
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  apb_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [31:0]            paddr_d, pwdata_d, rdata_d;
  logic                   pwrite_d, penable_d, ready_d, err_d;
  logic [APB_NUM_SLV-1:0] psel_d;

  logic [APB_NUM_SLV-1:0] req_sel, bus_sel;
  logic                   req_hit, bus_hit;
  logic                   pready_sel;
  logic [31:0]            prdata_sel;

  apb_decoder #(.BASE_ADDR(BASE_ADDR)) u_req_dec (
    .addr_page (addr[31:12]),
    .sel       (req_sel),
    .hit       (req_hit)
  );

  // Bus-side decode of the latched address steers the response path
  apb_decoder #(.BASE_ADDR(BASE_ADDR)) u_bus_dec (
    .addr_page (PADDR[31:12]),
    .sel       (bus_sel),
    .hit       (bus_hit)
  );

  assign pready_sel = bus_hit & (|(bus_sel & {PREADY3, PREADY2, PREADY1, PREADY0}));

  assign prdata_sel = ({32{bus_sel[SLV_GPIO]}}  & PRDATA0) |
                      ({32{bus_sel[SLV_UART]}}  & PRDATA1) |
                      ({32{bus_sel[SLV_TIMER]}} & PRDATA2) |
                      ({32{bus_sel[SLV_RSVD]}}  & PRDATA3);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    pwrite_d  = PWRITE;
    psel_d    = PSEL;
    penable_d = PENABLE;
    rdata_d   = rdata;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        if (transfer) begin
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          if (req_hit) begin
            psel_d  = req_sel;
            cnt_d   = '0;
            state_d = SETUP;
          end else begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // A PREADY in the last allowed cycle still wins over the timeout
        if (pready_sel) begin
          if (!PWRITE) rdata_d = prdata_sel;
          ready_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == TO_LAST) begin
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PWRITE  <= 1'b0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      PWRITE  <= pwrite_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized traffic
// against a transaction-level model of decode, latency, timeout and read data.
module tb_apb_master;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          TIMEOUT = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer, write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;

  int          checks = 0;
  int          errors = 0;

  int          wait_n [4];
  logic [31:0] prdata_val [4];
  logic        pready_q [4];
  int          scnt [4];
  logic        noise_en;
  logic [31:0] model_rdata;

  always #5 PCLK = ~PCLK;

  apb_master #(.BASE_ADDR(BASE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
    .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
  );

  assign PRDATA0 = prdata_val[0];
  assign PRDATA1 = prdata_val[1];
  assign PRDATA2 = prdata_val[2];
  assign PRDATA3 = prdata_val[3];
  assign PREADY0 = pready_q[0];
  assign PREADY1 = pready_q[1];
  assign PREADY2 = pready_q[2];
  assign PREADY3 = pready_q[3];

  // Slave models: registered PREADY after wait_n ACCESS cycles (0 = never);
  // unselected slaves may toggle PREADY randomly to prove it is ignored.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < 4; i++) begin
        scnt[i]     <= 0;
        pready_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (PSEL[i] && PENABLE) begin
          scnt[i]     <= scnt[i] + 1;
          pready_q[i] <= (wait_n[i] != 0) && (scnt[i] + 1 >= wait_n[i]);
        end else begin
          scnt[i]     <= 0;
          pready_q[i] <= (!PSEL[i] && noise_en) ? 1'($urandom) : 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Drives one request from the current cycle and checks every cycle up to completion.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    logic        hit;
    int          idx;
    logic [3:0]  exp_sel;
    int          done_edge;
    logic        exp_err;
    logic [31:0] exp_rd;
    hit     = (a[31:16] == BASE[31:16]) && (a[15:12] < 4'd4);
    idx     = int'(a[13:12]);
    exp_sel = hit ? (4'b0001 << idx) : 4'b0000;
    if (!hit) begin
      done_edge = 0; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (wait_n[idx] == 0 || wait_n[idx] >= TIMEOUT) begin
      done_edge = TIMEOUT + 1; exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      done_edge = 2 + wait_n[idx]; exp_err = 1'b0;
      exp_rd = w ? model_rdata : prdata_val[idx];
    end
    transfer = 1'b1; addr = a; write = w; wdata = d;
    tick();
    transfer = 1'b0; addr = $urandom; wdata = $urandom; write = 1'($urandom);
    for (int k = 0; k < done_edge; k++) begin
      checks++;
      if ({ready, err} !== 2'b00) begin
        $display("FAIL early_ready addr=%h cyc=%0d got ready/err=%b%b want 00", a, k + 1, ready, err);
        errors++;
      end
      checks++;
      if ({PSEL, PENABLE, PWRITE} !== {exp_sel, (k >= 1), w}) begin
        $display("FAIL bus_ctrl addr=%h cyc=%0d got psel/en/wr=%b/%b/%b want %b/%b/%b",
                 a, k + 1, PSEL, PENABLE, PWRITE, exp_sel, (k >= 1), w);
        errors++;
      end
      checks++;
      if ({PADDR, PWDATA, rdata} !== {a, d, model_rdata}) begin
        $display("FAIL bus_data addr=%h cyc=%0d got paddr/pwdata/rdata=%h/%h/%h want %h/%h/%h",
                 a, k + 1, PADDR, PWDATA, rdata, a, d, model_rdata);
        errors++;
      end
      tick();
    end
    checks++;
    if ({ready, err, rdata} !== {1'b1, exp_err, exp_rd}) begin
      $display("FAIL completion addr=%h wr=%b cyc=%0d got ready/err/rdata=%b/%b/%h want 1/%b/%h",
               a, w, done_edge + 1, ready, err, rdata, exp_err, exp_rd);
      errors++;
    end
    checks++;
    if ({PSEL, PENABLE} !== 5'b0) begin
      $display("FAIL bus_release addr=%h got psel/en=%b/%b want 0000/0", a, PSEL, PENABLE);
      errors++;
    end
    model_rdata = exp_rd;
  endtask

  task automatic test_reset();
    checks++;
    if ({rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL} !== '0) begin
      $display("FAIL reset_outputs got rdata=%h ready=%b err=%b paddr=%h psel=%b en=%b want all 0",
               rdata, ready, err, PADDR, PSEL, PENABLE);
      errors++;
    end
  endtask

  task automatic test_write_gpio();
    for (int i = 0; i < 4; i++) wait_n[i] = 1;
    run_xfer(32'h1000_0000, 1'b1, 32'h0000_000F);
  endtask

  task automatic test_read_gpio();
    prdata_val[0] = 32'h0000_0005;
    for (int i = 1; i < 4; i++) prdata_val[i] = 32'hDEAD_BEEF;
    run_xfer(32'h1000_0004, 1'b0, 32'h0);
  endtask

  task automatic test_decode_miss();
    run_xfer(32'h2000_0000, 1'b0, 32'h1234_5678);
    run_xfer(32'h1000_4000, 1'b1, 32'hCAFE_0001);
    tick();
    checks++;
    if ({ready, err, PSEL} !== 6'b0) begin
      $display("FAIL miss_pulse_width got ready/err/psel=%b/%b/%b want 0/0/0000", ready, err, PSEL);
      errors++;
    end
  endtask

  task automatic test_timeout();
    wait_n[2] = 0;
    run_xfer(32'h1000_2000, 1'b0, 32'h0);
    wait_n[0] = 1;
    prdata_val[0] = 32'h0000_00A5;
    run_xfer(32'h1000_0008, 1'b0, 32'h0);
    wait_n[1] = TIMEOUT - 1;
    prdata_val[1] = 32'h5A5A_0001;
    run_xfer(32'h1000_1000, 1'b0, 32'h0);
    wait_n[1] = TIMEOUT;
    run_xfer(32'h1000_1004, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wait_n[i] = i + 1;
      prdata_val[i] = 32'hB000_0000 + i;
    end
    run_xfer(32'h1000_3000, 1'b0, 32'h0);
    run_xfer(32'h1000_1010, 1'b1, 32'h1111_2222);
    run_xfer(32'h3000_0000, 1'b0, 32'h0);
    run_xfer(32'h1000_2020, 1'b0, 32'h0);
    run_xfer(32'h1000_0030, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    wait_n[0] = 5;
    transfer = 1'b1; addr = 32'h1000_0010; write = 1'b0; wdata = 32'h0;
    tick();
    transfer = 1'b0;
    tick();
    tick();
    PRESET = 1'b1; transfer = 1'b1;
    #1;
    checks++;
    if ({rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL} !== '0) begin
      $display("FAIL reset_abort got ready=%b psel=%b en=%b paddr=%h rdata=%h want all 0",
               ready, PSEL, PENABLE, PADDR, rdata);
      errors++;
    end
    tick();
    checks++;
    if ({rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL} !== '0) begin
      $display("FAIL reset_hold got ready=%b psel=%b en=%b paddr=%h want all 0", ready, PSEL, PENABLE, PADDR);
      errors++;
    end
    transfer = 1'b0;
    tick();
    PRESET = 1'b0;
    model_rdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({ready, PSEL, PENABLE} !== 6'b0) begin
        $display("FAIL post_reset_quiet cyc=%0d got ready/psel/en=%b/%b/%b want 0", k, ready, PSEL, PENABLE);
        errors++;
      end
    end
    wait_n[0] = 1;
    prdata_val[0] = 32'h0000_0777;
    run_xfer(32'h1000_0014, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          r;
    noise_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = int'($urandom_range(0, 24));
        wait_n[i] = (r == 0) ? 0 : (r == 1) ? TIMEOUT - 1 : (r == 2) ? TIMEOUT : int'($urandom_range(1, 5));
        prdata_val[i] = $urandom;
      end
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        a = $urandom;
        if (a[31:16] == BASE[31:16]) a[31:16] = a[31:16] ^ 16'h0100;
      end else if (r == 1) begin
        a = {BASE[31:16], 4'($urandom_range(4, 15)), 12'($urandom)};
      end else begin
        a = {BASE[31:16], 2'b00, 2'($urandom_range(0, 3)), 12'($urandom)};
      end
      run_xfer(a, 1'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        checks++;
        if (ready !== 1'b0) begin
          $display("FAIL ready_width n=%0d got ready=%b want 0", n, ready);
          errors++;
        end
      end
    end
    noise_en = 1'b0;
    tick();
  endtask

  initial begin
    PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
    noise_en = 1'b0; model_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      wait_n[i] = 1;
      prdata_val[i] = 32'h0;
    end
    tick();
    tick();
    test_reset();
    PRESET = 1'b0;
    tick();
    test_write_gpio();
    test_read_gpio();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
